spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  System-clocked SPI master that sequences byte transfers to an spi_slave.
//  Generates ss/sclk/mosi in SPI mode 0, LSB first, and captures miso.
//  Requesters queue bytes through a valid/ready port. Received bytes return as one-cycle pulses.
//  Non-last bytes keep ss asserted, so multi-byte frames form one SPI transaction.
// PARAMETERS
//  CLK_DIV   4   clk cycles per sclk half-period; legal range >= 1
//  SS_GAP    4   clk cycles ss stays high after a frame before the next accept
// PORTS
//  clk       in   1  system clock; all logic on rising edge
//  rst       in   1  asynchronous, active-high reset
//  tx_valid  in   1  requester has a byte to send
//  tx_data   in   8  byte to send; sampled on accept
//  tx_last   in   1  byte ends the frame; ss deasserts after it; sampled on accept
//  tx_ready  out  1  controller can accept a byte this cycle
//  rx_valid  out  1  one-cycle pulse: rx_data holds the byte received in the same slot
//  rx_data   out  8  last received byte; holds until next rx_valid
//  busy      out  1  high whenever state != IDLE
//  ss        out  1  slave select, active low
//  sclk      out  1  SPI clock, idle low
//  mosi      out  1  master out; changes only while sclk = 0
//  miso      in   1  master in
// BEHAVIOUR
//  Reset (async, immediate): ss=1, sclk=0, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0.
//   The FSM goes to IDLE. A partially shifted byte is discarded and produces no rx_valid.
//  Accept: tx_valid & tx_ready on a rising clk edge latches tx_data and tx_last.
//   tx_ready = 1 only in IDLE and WAIT_NEXT.
//  States:
//   IDLE: ss=1, sclk=0. On accept -> SETUP.
//   SETUP: on the entry edge, ss=0 and mosi=tx_data[0]. Hold CLK_DIV cycles -> HIGH.
//   HIGH: on the entry edge, sclk=1 and miso is shifted into bit[i] of the rx shift register.
//    Hold CLK_DIV cycles.
//    If i<7 -> LOW. If i==7 -> BYTE_DONE.
//   LOW: on the entry edge, sclk=0 and mosi=tx bit[i+1]. Hold CLK_DIV cycles -> HIGH.
//   BYTE_DONE (1 cycle): sclk=0, rx_valid=1, rx_data=shift register.
//    If the latched tx_last=1 -> HOLD. Otherwise -> WAIT_NEXT.
//   WAIT_NEXT: ss=0, sclk=0, mosi holds its last value. Waits indefinitely.
//    On accept -> SETUP; SETUP leaves ss low and drives the new bit0.
//   HOLD: ss=0 for CLK_DIV cycles (ss hold time) -> GAP.
//   GAP: ss=1 for SS_GAP cycles -> IDLE.
//  Timing:
//   - Accept to first sclk rise: CLK_DIV+1 clk edges.
//   - One byte is 8 sclk periods of 2*CLK_DIV clk each.
//   - rx_valid comes CLK_DIV+1 edges after the 8th sclk rise.
//  Counter: a phase counter of width $clog2(max(CLK_DIV,SS_GAP)+1).
//   It reloads on every state entry and never wraps.
//  Bit index: 3 bits, counts 0..7, cleared in SETUP.
//  Simultaneous events: an accept in the WAIT_NEXT cycle right after BYTE_DONE is legal.
//   rx_valid has no backpressure; the consumer must take it in that cycle.
//  tx_valid while busy outside WAIT_NEXT is ignored (tx_ready=0); requesters must hold their data.
//  sclk and mosi are never 1 while ss=1.
// TESTING
//  1. Assert rst mid-sim -> all outputs take their reset values without waiting for a clk edge.
//  2. CLK_DIV=2, send 0x0D with tx_last=1; miso model returns 0x50 LSB first.
//     Required: mosi bits 1,0,1,1,0,0,0,0; exactly 8 sclk pulses; one rx_valid with rx_data=0x50;
//     ss high 2 cycles after BYTE_DONE.
//  3. Burst 0x11,0x22,0x33 with tx_valid held (last on 0x33).
//     Required: ss low throughout; 24 sclk pulses; 3 rx_valid pulses; tx_ready pulses between bytes.
//  4. Byte 0x5A (tx_last=0), then tx_valid low for 20 cycles.
//     Required: ss low, sclk low, busy=1, no extra pulses.
//     Then send 0xA5 (tx_last=1): correct bits follow.
//  5. Assert rst while sending bit 3 -> ss=1 immediately; no rx_valid.
//     A fresh 0xC3 transfer afterwards is bit-exact.
//  6. Loopback to an spi_slave instance; master sends 0xA5, slave tx_data=0x3C.
//     Required: master rx_data=0x3C; slave rx_data=0xA5 with rx_data_available.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Requester-side byte port plus SPI pins of the SPI master controller.
interface spi_master_ctrl_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       miso;

    modport master (
        input  tx_valid, tx_data, tx_last, miso,
        output tx_ready, rx_valid, rx_data, busy, ss, sclk, mosi
    );

    modport slave (
        output tx_valid, tx_data, tx_last, miso,
        input  tx_ready, rx_valid, rx_data, busy, ss, sclk, mosi
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, LSB first; queued bytes are framed under one ss assertion until tx_last.
// Phase timing comes from a down-counter reloaded on every state entry; all outputs are registered.
//
// state     | meaning
// IDLE      | ss high, waiting for the first byte of a frame
// SETUP     | ss low, bit0 on mosi ahead of the first sclk rise
// HIGH      | sclk high, miso captured on entry
// LOW       | sclk low, next mosi bit driven on entry
// BYTE_DONE | one-cycle rx_valid pulse
// WAIT_NEXT | frame open, ss held low until the next byte arrives
// HOLD      | ss hold time after the last byte of a frame
// GAP       | ss high before a new frame may start
module spi_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_ctrl_if.master bus
);

    localparam int CNT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((SS_GAP > 0) ? SS_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_BYTE_DONE,
        S_WAIT_NEXT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nxt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic             last_q;
    logic             accept;

    logic             ss_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             tx_ready_q;
    logic             rx_valid_q;
    logic [7:0]       rx_data_q;
    logic             busy_q;

    assign bit_nxt = bit_idx + 3'd1;
    assign accept  = bus.tx_valid & tx_ready_q;

    assign bus.ss       = ss_q;
    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            last_q     <= 1'b0;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                S_IDLE, S_WAIT_NEXT: begin
                    tx_ready_q <= 1'b1;
                    if (accept) begin
                        tx_sr      <= bus.tx_data;
                        last_q     <= bus.tx_last;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        ss_q       <= 1'b0;
                        mosi_q     <= bus.tx_data[0];
                        bit_idx    <= '0;
                        cnt        <= DIV_LOAD;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP, S_LOW: begin
                    if (cnt == '0) begin
                        sclk_q         <= 1'b1;
                        rx_sr[bit_idx] <= bus.miso;
                        cnt            <= DIV_LOAD;
                        state          <= S_HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt == '0) begin
                        sclk_q <= 1'b0;
                        cnt    <= DIV_LOAD;
                        if (bit_idx == 3'd7) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sr;
                            state      <= S_BYTE_DONE;
                        end else begin
                            bit_idx <= bit_nxt;
                            mosi_q  <= tx_sr[bit_nxt];
                            state   <= S_LOW;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_BYTE_DONE: begin
                    if (last_q) begin
                        cnt   <= DIV_LOAD;
                        state <= S_HOLD;
                    end else begin
                        tx_ready_q <= 1'b1;
                        state      <= S_WAIT_NEXT;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        // mosi returns low together with ss so neither toggles outside a frame
                        ss_q   <= 1'b1;
                        mosi_q <= 1'b0;
                        cnt    <= GAP_LOAD;
                        state  <= S_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: behavioural SPI slave, per-cycle reference model, directed and random bytes.
module tb_spi_master_ctrl;
    localparam int CD = 2;
    localparam int SG = 3;
    localparam int PH_IDLE = 0;
    localparam int PH_BYTE = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_TAIL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_master_ctrl_if bus_if();

    spi_master_ctrl #(.CLK_DIV(CD), .SS_GAP(SG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int epoch  = 0;
    int st_cnt = 0;
    logic [7:0] miso_tab [0:2047];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int key(input int c);
        return epoch * 128 + c;
    endfunction

    // Slave: presents miso bits as the master clocks, collects mosi bytes
    logic [2:0] s_bit;
    int         s_cnt;
    logic [7:0] s_sr;
    logic [7:0] s_last;
    int         s_nbytes;

    always @(posedge bus_if.sclk or posedge rst) begin
        if (rst) begin
            s_bit    <= '0;
            s_cnt    <= 0;
            s_sr     <= '0;
            s_last   <= '0;
            s_nbytes <= 0;
        end else begin
            s_sr[s_bit] <= bus_if.mosi;
            s_bit       <= s_bit + 3'd1;
            if (s_bit == 3'd7) begin
                s_last   <= {bus_if.mosi, s_sr[6:0]};
                s_nbytes <= s_nbytes + 1;
                s_cnt    <= s_cnt + 1;
            end
        end
    end

    assign bus_if.miso = bus_if.ss ? 1'b0 : miso_tab[key(s_cnt)][s_bit];

    int n_sclk = 0;
    int n_ss_rise = 0;
    int n_rxv = 0;
    int n_ready_busy = 0;
    always @(posedge bus_if.sclk) n_sclk <= n_sclk + 1;
    always @(posedge bus_if.ss) n_ss_rise <= n_ss_rise + 1;

    // Reference model: a byte occupies 16*CD cycles after its accept, the last of which carries rx_valid
    int         m_ph;
    int         m_t;
    bit         m_fresh;
    logic [7:0] m_d;
    bit         m_l;
    logic [7:0] m_rx;
    int         m_cnt;

    initial begin
        bit acc;
        m_ph = PH_IDLE; m_t = 0; m_fresh = 1; m_d = '0; m_l = 0; m_rx = '0; m_cnt = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_ph = PH_IDLE; m_t = 0; m_fresh = 1; m_rx = '0; m_cnt = 0;
            end else begin
                acc = bus_if.tx_valid && ((m_ph == PH_IDLE && !m_fresh) || m_ph == PH_WAIT);
                case (m_ph)
                    PH_IDLE, PH_WAIT: begin
                        m_fresh = 0;
                        if (acc) begin
                            m_ph = PH_BYTE; m_t = 0; m_d = bus_if.tx_data; m_l = bus_if.tx_last;
                        end
                    end
                    PH_BYTE: begin
                        if (m_t < 16 * CD) begin
                            m_t++;
                            if (m_t == 16 * CD) begin
                                m_rx = miso_tab[key(m_cnt)];
                                m_cnt++;
                            end
                        end else if (m_l) begin
                            m_ph = PH_TAIL; m_t = 0;
                        end else begin
                            m_ph = PH_WAIT;
                        end
                    end
                    default: begin
                        if (m_t == CD + SG - 1) m_ph = PH_IDLE;
                        else m_t++;
                    end
                endcase
            end
        end
    end

    initial begin
        logic e_ss, e_sclk, e_mosi, e_busy, e_ready, e_rxv;
        int k, i;
        forever begin
            @(negedge clk);
            if (!rst) begin
                e_ss = 1; e_sclk = 0; e_mosi = 0; e_busy = 0; e_ready = 0; e_rxv = 0;
                case (m_ph)
                    PH_IDLE: e_ready = !m_fresh;
                    PH_BYTE: begin
                        e_ss = 0; e_busy = 1;
                        if (m_t < CD) begin
                            e_mosi = m_d[0];
                        end else if (m_t < 16 * CD) begin
                            k = (m_t - CD) / CD;
                            i = k / 2;
                            if (k % 2 == 0) begin
                                e_sclk = 1; e_mosi = m_d[i];
                            end else begin
                                e_mosi = m_d[i + 1];
                            end
                        end else begin
                            e_mosi = m_d[7]; e_rxv = 1;
                        end
                    end
                    PH_WAIT: begin
                        e_ss = 0; e_busy = 1; e_ready = 1; e_mosi = m_d[7];
                    end
                    default: begin
                        e_busy = 1;
                        if (m_t < CD) begin
                            e_ss = 0; e_mosi = m_d[7];
                        end
                    end
                endcase
                chk("ss", bus_if.ss, e_ss);
                chk("sclk", bus_if.sclk, e_sclk);
                chk("mosi", bus_if.mosi, e_mosi);
                chk("busy", bus_if.busy, e_busy);
                chk("tx_ready", bus_if.tx_ready, e_ready);
                chk("rx_valid", bus_if.rx_valid, e_rxv);
                chk("rx_data", bus_if.rx_data, m_rx);
                chk("lines_quiet_when_deselected", bus_if.ss && (bus_if.sclk || bus_if.mosi), 0);
                if (bus_if.rx_valid) n_rxv++;
                if (bus_if.tx_ready && bus_if.busy) n_ready_busy++;
            end
        end
    end

    task automatic do_reset();
        epoch++;
        st_cnt = 0;
        #2 rst = 1'b1;
        #1 chk("reset_outputs",
               {bus_if.ss, bus_if.sclk, bus_if.mosi, bus_if.tx_ready, bus_if.rx_valid, bus_if.busy, bus_if.rx_data},
               {1'b1, 13'h0});
        bus_if.tx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit last, input logic [7:0] m);
        bit got;
        miso_tab[key(st_cnt)] = m;
        st_cnt++;
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = d;
        bus_if.tx_last  = last;
        got = 0;
        for (int n = 0; n < 400 && !got; n++) begin
            if (bus_if.tx_ready) got = 1;
            else @(negedge clk);
        end
        chk("accept_timeout", got, 1);
        @(negedge clk);
    endtask

    task automatic wait_rxv(input string nm);
        bit got;
        got = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            got = bus_if.rx_valid;
        end
        chk(nm, got, 1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            got = !bus_if.busy && bus_if.tx_ready;
        end
        chk("idle_timeout", got, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_sclk, b_rxv, b_ss, b_rb, b_sn;
        logic [7:0] m;
        bit got;
        bit last;
        for (int j = 0; j < 2048; j++) miso_tab[j] = '0;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = '0;
        bus_if.tx_last  = 1'b0;

        // single byte, frame closes after it
        @(negedge clk);
        do_reset();
        b_sclk = n_sclk; b_rxv = n_rxv;
        send(8'h0D, 1, 8'h50);
        bus_if.tx_valid = 1'b0;
        wait_rxv("t2_rx_valid_seen");
        chk("t2_rx_data", bus_if.rx_data, 8'h50);
        @(negedge clk); chk("t2_ss_hold1", bus_if.ss, 0);
        @(negedge clk); chk("t2_ss_hold2", bus_if.ss, 0);
        @(negedge clk); chk("t2_ss_gap", bus_if.ss, 1);
        wait_idle();
        chk("t2_sclk_pulses", n_sclk - b_sclk, 8);
        chk("t2_rx_valid_pulses", n_rxv - b_rxv, 1);
        chk("t2_mosi_byte", s_last, 8'h0D);

        // three-byte burst with tx_valid held
        b_sclk = n_sclk; b_rxv = n_rxv; b_ss = n_ss_rise; b_rb = n_ready_busy;
        send(8'h11, 0, 8'h81);
        send(8'h22, 0, 8'h42);
        send(8'h33, 1, 8'hC3);
        bus_if.tx_valid = 1'b0;
        wait_idle();
        chk("t3_sclk_pulses", n_sclk - b_sclk, 24);
        chk("t3_rx_valid_pulses", n_rxv - b_rxv, 3);
        chk("t3_ss_rises", n_ss_rise - b_ss, 1);
        chk("t3_ready_between_bytes", n_ready_busy - b_rb, 2);
        chk("t3_last_mosi_byte", s_last, 8'h33);

        // open frame left waiting, then closed
        b_sclk = n_sclk;
        send(8'h5A, 0, 8'h0F);
        bus_if.tx_valid = 1'b0;
        wait_rxv("t4_rx_valid_seen");
        repeat (20) @(negedge clk);
        chk("t4_wait_ss", bus_if.ss, 0);
        chk("t4_wait_sclk", bus_if.sclk, 0);
        chk("t4_wait_busy", bus_if.busy, 1);
        chk("t4_wait_pulses", n_sclk - b_sclk, 8);
        send(8'hA5, 1, 8'hE1);
        bus_if.tx_valid = 1'b0;
        wait_idle();
        chk("t4_second_mosi_byte", s_last, 8'hA5);
        chk("t4_second_rx_data", bus_if.rx_data, 8'hE1);
        chk("t4_total_pulses", n_sclk - b_sclk, 16);

        // reset while bit 3 is on the wire
        do_reset();
        b_sclk = n_sclk; b_rxv = n_rxv;
        send(8'hE7, 1, 8'h77);
        bus_if.tx_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = (n_sclk - b_sclk) == 4;
        end
        chk("t5_reach_bit3", got, 1);
        do_reset();
        repeat (3) @(negedge clk);
        chk("t5_no_rx_valid", n_rxv - b_rxv, 0);
        chk("t5_slave_no_byte", s_nbytes, 0);
        send(8'hC3, 1, 8'h96);
        bus_if.tx_valid = 1'b0;
        wait_idle();
        chk("t5_fresh_mosi_byte", s_last, 8'hC3);
        chk("t5_fresh_rx_data", bus_if.rx_data, 8'h96);

        // loopback exchange
        b_sn = s_nbytes;
        send(8'hA5, 1, 8'h3C);
        bus_if.tx_valid = 1'b0;
        wait_idle();
        chk("t6_master_rx", bus_if.rx_data, 8'h3C);
        chk("t6_slave_rx", s_last, 8'hA5);
        chk("t6_slave_available", s_nbytes - b_sn, 1);

        // random bytes, frame lengths and idle gaps
        do_reset();
        b_rxv = n_rxv;
        for (int j = 0; j < 50; j++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                bus_if.tx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            last = (j == 49) || ($urandom_range(0, 2) == 0);
            m = 8'($urandom);
            send(8'($urandom), last, m);
        end
        bus_if.tx_valid = 1'b0;
        wait_idle();
        chk("rand_rx_valid_pulses", n_rxv - b_rxv, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
